// File: rtl/serial_add_unit_if.sv
// Request/result bundle for the bit-serial add/subtract engine.
// The master issues operations; the slave (serial_add_unit) returns results and flags.
interface serial_add_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, overflow, zero
  );
endinterface

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract: one full adder plus a carry flop walks the operands LSB first,
// then commits sum, carry-out, signed overflow and zero in a single edge.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_add_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Only WIDTH-1 partial sum bits are kept; the final bit comes straight from the adder.
  logic [WIDTH-2:0] r_s;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sumNext;
  logic             w_last;

  full_adder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_co)
  );

  assign w_sumNext = {w_s, r_s};
  assign w_last    = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // Subtraction is a + ~b + 1, with the +1 injected as the initial carry.
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_count <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_s     <= w_sumNext[WIDTH-1:1];
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_co;
          r_count <= r_count + CW'(1);
          // On the last bit r_carry is the carry into the MSB, needed for signed overflow.
          if (w_last) begin
            r_sum   <= w_sumNext;
            r_cout  <= w_co;
            r_ovf   <= r_carry ^ w_co;
            r_zero  <= (w_sumNext == '0);
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;
  assign bus.zero     = r_zero;
endmodule
